// File: rtl/audio_stream_dac.sv
// -----------------------------------------------------------------------------
// audio_stream_dac
//
// Multi-channel audio playback engine. Frames (one sample per channel) are
// written into a frame FIFO. A sample timer pops one frame every RATE_DIV
// cycles into per-channel sample registers. Each channel drives a 1-bit
// output through either a PWM or a first-order sigma-delta modulator.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   wr_en        write-one-frame strobe
//   wr_data      frame, channel 0 in the least significant SAMPLE_W bits
//   enable       playback run (0 = stopped, modulators and timer held at 0)
//   mode         0 = PWM, 1 = first-order sigma-delta
//   clr_flags    clears the sticky underrun/overflow flags
//   full         FIFO holds FIFO_DEPTH frames
//   level        number of frames stored
//   sample_tick  one-cycle pulse following a frame pop
//   underrun     sticky: a sample period found the FIFO empty
//   overflow     sticky: a write was dropped because the FIFO was full
//   analog       one modulated bit per channel
// -----------------------------------------------------------------------------
module audio_stream_dac #(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int RATE_DIV   = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [CHANNELS*SAMPLE_W-1:0]   wr_data,
  input  logic                           enable,
  input  logic                           mode,
  input  logic                           clr_flags,
  output logic                           full,
  output logic [$clog2(FIFO_DEPTH):0]    level,
  output logic                           sample_tick,
  output logic                           underrun,
  output logic                           overflow,
  output logic [CHANNELS-1:0]            analog
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int TMR_W   = $clog2(RATE_DIV);
  localparam int FRAME_W = CHANNELS * SAMPLE_W;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RATE_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0]  mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                full_q, full_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [SAMPLE_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SAMPLE_W:0]   acc_q [CHANNELS];
  logic [SAMPLE_W:0]   acc_d [CHANNELS];
  logic [SAMPLE_W-1:0] sample_q [CHANNELS];
  logic [SAMPLE_W-1:0] sample_d [CHANNELS];
  logic                sample_tick_q, sample_tick_d;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;
  logic [CHANNELS-1:0] analog_q, analog_d;
  logic                mode_q;

  // Per-cycle events
  logic                push;      // accepted write
  logic                drop;      // write refused because FIFO is full
  logic                tick;      // end of a sample period
  logic                pop;       // tick that finds a frame to load
  logic                starve;    // tick that finds the FIFO empty
  logic                mode_chg;  // modulator selection changed this cycle
  logic                mod_clear; // modulators forced back to their start state
  logic [FRAME_W-1:0]  head;
  logic [SAMPLE_W:0]   acc_sum [CHANNELS];

  assign head = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default at the top so
  // no path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    push      = wr_en && !full_q;
    drop      = wr_en && full_q;
    tick      = enable && (timer_q == TMR_LAST);
    pop       = tick && (level_q != '0);
    starve    = tick && (level_q == '0);
    mode_chg  = (mode != mode_q);
    mod_clear = !enable || mode_chg;

    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    // A simultaneous push and pop leaves the occupancy unchanged.
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    full_d = (level_d == LVL_FULL);

    // The timer only runs while playing, so the first tick comes a full
    // sample period after enable rises.
    timer_d       = (mod_clear && !enable) || tick ? '0 : timer_q + TMR_W'(1);
    pwm_cnt_d     = mod_clear ? '0 : pwm_cnt_q + SAMPLE_W'(1);
    sample_tick_d = pop;

    // A new set event wins over a clear request in the same cycle.
    underrun_d = starve ? 1'b1 : (clr_flags ? 1'b0 : underrun_q);
    overflow_d = drop   ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);

    for (int n = 0; n < CHANNELS; n++) begin
      sample_d[n] = pop ? head[n*SAMPLE_W +: SAMPLE_W] : sample_q[n];

      // Sigma-delta: add the sample to the residue; the carry is the output
      // bit, so the density of ones is sample / 2^SAMPLE_W.
      acc_sum[n] = {1'b0, acc_q[n][SAMPLE_W-1:0]} + {1'b0, sample_q[n]};

      if (mod_clear) begin
        acc_d[n]    = '0;
        analog_d[n] = 1'b0;
      end else if (mode) begin
        acc_d[n]    = acc_sum[n];
        analog_d[n] = acc_sum[n][SAMPLE_W];
      end else begin
        acc_d[n]    = '0;
        analog_d[n] = (pwm_cnt_q < sample_q[n]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      timer_q       <= '0;
      pwm_cnt_q     <= '0;
      sample_tick_q <= 1'b0;
      underrun_q    <= 1'b0;
      overflow_q    <= 1'b0;
      analog_q      <= '0;
      mode_q        <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        acc_q[n]    <= '0;
        sample_q[n] <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      full_q        <= full_d;
      timer_q       <= timer_d;
      pwm_cnt_q     <= pwm_cnt_d;
      sample_tick_q <= sample_tick_d;
      underrun_q    <= underrun_d;
      overflow_q    <= overflow_d;
      analog_q      <= analog_d;
      mode_q        <= mode;
      for (int n = 0; n < CHANNELS; n++) begin
        acc_q[n]    <= acc_d[n];
        sample_q[n] <= sample_d[n];
      end
    end
  end

  // NOTE: the frame storage has no reset; resetting the pointers and level
  // already makes old contents unreachable, and a reset-free array maps onto
  // plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign full        = full_q;
  assign level       = level_q;
  assign sample_tick = sample_tick_q;
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;
  assign analog      = analog_q;

endmodule

// File: tb/tb_audio_stream_dac.sv
// -----------------------------------------------------------------------------
// tb_audio_stream_dac
//
// Two instances share clock and reset:
//   dut_a  RATE_DIV=8    tick timing, PWM duty, sigma-delta pattern,
//                        simultaneous events, reset during playback
//   dut_b  RATE_DIV=512  fill/overflow and full readback; every accepted frame
//                        is queued as the expected PWM duty of each channel,
//                        and a monitor compares on each sample_tick.
// -----------------------------------------------------------------------------
module tb_audio_stream_dac;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // dut_a signals
  logic        a_wr_en, a_enable, a_mode, a_clr;
  logic [15:0] a_wr_data;
  logic        a_full, a_tick, a_underrun, a_overflow;
  logic [4:0]  a_level;
  logic [1:0]  a_analog;

  // dut_b signals
  logic        b_wr_en, b_enable, b_mode, b_clr;
  logic [15:0] b_wr_data;
  logic        b_full, b_tick, b_underrun, b_overflow;
  logic [4:0]  b_level;
  logic [1:0]  b_analog;

  audio_stream_dac #(
    .CHANNELS(2), .SAMPLE_W(8), .FIFO_DEPTH(16), .RATE_DIV(8)
  ) dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .enable(a_enable), .mode(a_mode), .clr_flags(a_clr),
    .full(a_full), .level(a_level), .sample_tick(a_tick),
    .underrun(a_underrun), .overflow(a_overflow), .analog(a_analog)
  );

  audio_stream_dac #(
    .CHANNELS(2), .SAMPLE_W(8), .FIFO_DEPTH(16), .RATE_DIV(512)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .enable(b_enable), .mode(b_mode), .clr_flags(b_clr),
    .full(b_full), .level(b_level), .sample_tick(b_tick),
    .underrun(b_underrun), .overflow(b_overflow), .analog(b_analog)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_write(input logic [15:0] d);
    a_wr_en   = 1'b1;
    a_wr_data = d;
    step();
    a_wr_en   = 1'b0;
  endtask

  task automatic a_wait_tick(input string name);
    for (int k = 0; k < 64 && a_tick !== 1'b1; k++) step();
    check(name, a_tick, 1);
  endtask

  task automatic a_count(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      c0 += int'(a_analog[0]);
      c1 += int'(a_analog[1]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // dut_b scoreboard: expected frames in write order; {ch1, ch0}
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic        b_busy = 1'b0;
  logic [15:0] b_exp;
  int          b_c0, b_c1;

  initial begin
    forever begin
      @(negedge clk);
      if (b_tick === 1'b1) begin
        b_busy = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL b_extra_frame: sample_tick with no frame expected");
        end else begin
          b_exp = exp_q.pop_front();
          b_c0  = 0;
          b_c1  = 0;
          repeat (256) begin
            @(negedge clk);
            b_c0 += int'(b_analog[0]);
            b_c1 += int'(b_analog[1]);
          end
          check("b_duty_ch0", b_c0, 32'(b_exp[7:0]));
          check("b_duty_ch1", b_c1, 32'(b_exp[15:8]));
        end
        b_busy = 1'b0;
      end
    end
  end

  // Seventeen frames; the last one must be dropped.
  logic [15:0] fill_tbl [17] = '{
    16'h0A05, 16'h14F0, 16'h00FF, 16'hFF00, 16'h8040, 16'h3C7F,
    16'h0180, 16'h55AA, 16'hC3E1, 16'h0203, 16'h7E81, 16'h1F20,
    16'h9999, 16'h4010, 16'hEE11, 16'h6B2C, 16'hDEAD
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int c0, c1, b_mlevel;

    rst = 1'b1;
    a_wr_en = 0; a_enable = 0; a_mode = 0; a_clr = 0; a_wr_data = '0;
    b_wr_en = 0; b_enable = 0; b_mode = 0; b_clr = 0; b_wr_data = '0;
    step(2);

    // Reset state
    check("rst_level", a_level, 0);
    check("rst_full", a_full, 0);
    check("rst_tick", a_tick, 0);
    check("rst_underrun", a_underrun, 0);
    check("rst_overflow", a_overflow, 0);
    check("rst_analog", a_analog, 0);
    rst = 1'b0;

    // Tick timing: 3 frames preloaded, enable rises in cycle T
    a_write(16'h1122);
    a_write(16'h3344);
    a_write(16'h5566);
    check("preload_level", a_level, 3);
    a_enable = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      step();
      check($sformatf("tick_T+%0d", i), a_tick, (i == 8 || i == 16 || i == 24));
      check($sformatf("level_T+%0d", i), a_level,
            (i < 8) ? 3 : (i < 16) ? 2 : (i < 24) ? 1 : 0);
      check($sformatf("underrun_T+%0d", i), a_underrun, (i >= 32));
    end

    // PWM duty: ch0=64, ch1=0
    a_enable = 1'b0;
    a_write(16'h0040);
    a_enable = 1'b1;
    a_wait_tick("pwm_tick_a");
    a_count(c0, c1);
    check("pwm_duty_64", c0, 64);
    check("pwm_duty_0", c1, 0);

    // PWM duty at the extremes: ch0=255, ch1=1
    a_write(16'h01FF);
    a_wait_tick("pwm_tick_b");
    a_count(c0, c1);
    check("pwm_duty_255", c0, 255);
    check("pwm_duty_1", c1, 1);

    // Sigma-delta: ch0=128, ch1=192, accumulators restarted from 0
    a_enable = 1'b0;
    a_mode   = 1'b1;
    a_write(16'hC080);
    a_enable = 1'b1;
    a_wait_tick("sd_tick");
    a_enable = 1'b0;
    step();
    check("off_analog", a_analog, 0);
    a_enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("sd128_%0d", i), a_analog[0], (i % 2 == 0));
      check($sformatf("sd192_%0d", i), a_analog[1], (i % 4 != 1));
    end

    // Write and pop together at level 5
    a_enable = 1'b0;
    a_mode   = 1'b0;
    step();
    for (int k = 1; k <= 5; k++) a_write(16'(k * 16'h0101));
    check("lvl5_pre", a_level, 5);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    check("clr_idle", a_underrun, 0);
    a_enable = 1'b1;                  // cycle T
    step(7);                          // cycle T+7: tick cycle
    a_wr_en   = 1'b1;
    a_wr_data = 16'h7777;
    step();                           // cycle T+8
    a_wr_en   = 1'b0;
    check("wr_pop_level", a_level, 5);
    check("wr_pop_tick", a_tick, 1);

    // Clear request coinciding with a new underrun (tick at T+55)
    step(47);
    check("underrun_pre", a_underrun, 0);
    a_clr = 1'b1;
    step();
    check("clr_vs_set", a_underrun, 1);
    step();
    check("clr_after", a_underrun, 0);
    a_clr = 1'b0;

    // Reset during playback at level 7
    step(7);
    check("underrun_again", a_underrun, 1);
    a_enable = 1'b0;
    for (int k = 0; k < 7; k++) a_write(16'hA0A0 + 16'(k));
    a_enable = 1'b1;
    step(2);
    check("pre_rst_level", a_level, 7);
    rst = 1'b1;
    step();
    check("mid_rst_level", a_level, 0);
    check("mid_rst_full", a_full, 0);
    check("mid_rst_underrun", a_underrun, 0);
    check("mid_rst_overflow", a_overflow, 0);
    check("mid_rst_analog", a_analog, 0);
    check("mid_rst_tick", a_tick, 0);
    rst = 1'b0;
    a_enable = 1'b0;
    a_write(16'h0001);
    check("first_write", a_level, 1);

    // dut_b: fill with 17 frames while stopped
    b_mlevel = 0;
    for (int k = 0; k < 17; k++) begin
      b_wr_en   = 1'b1;
      b_wr_data = fill_tbl[k];
      if (b_mlevel < 16) begin
        exp_q.push_back(fill_tbl[k]);
        b_mlevel++;
      end
      step();
    end
    b_wr_en = 1'b0;
    check("fill_level", b_level, 16);
    check("fill_full", b_full, 1);
    check("fill_overflow", b_overflow, 1);

    // Readback through PWM duty
    b_enable = 1'b1;
    for (int w = 0; w < 20000 && (exp_q.size() != 0 || b_busy); w++) step();
    check("b_drained", exp_q.size(), 0);
    step(1100);
    check("b_underrun_end", b_underrun, 1);
    check("b_level_end", b_level, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
